sad_buffer_sequencer: RTL and testbench

//   Sequences two serial 80-byte buffers (template, candidate) and the SAD unit for one block search.

---
 rtl/sad_buffer_sequencer_pkg.sv | 26 ++
 rtl/sad_buffer_sequencer_if.sv | 41 ++++
 rtl/sad_best_tracker.sv | 43 ++++
 rtl/sad_buffer_sequencer.sv | 138 +++++++++++++
 tb/tb_sad_buffer_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_buffer_sequencer_pkg.sv
// Shared sizing, FSM state encoding and derived constants for the SAD block-search sequencer.
package sad_buffer_sequencer_pkg;

   localparam int WIDTH    = 8;
   localparam int BUF_SIZE = 80;
   localparam int CNT_W    = 7;
   localparam int NUM_CAND = 16;
   localparam int IDX_W    = 4;
   localparam int SAD_W    = 15;

   localparam logic [CNT_W-1:0] BUF_CNT   = CNT_W'(BUF_SIZE);
   localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);
   localparam logic [SAD_W-1:0] SAD_MAX   = '1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLR_ALL   = 3'd1,
      ST_LOAD_TPL  = 3'd2,
      ST_LOAD_CAND = 3'd3,
      ST_RUN_SAD   = 3'd4,
      ST_WAIT_SAD  = 3'd5,
      ST_CLR_CAND  = 3'd6,
      ST_DONE      = 3'd7
   } state_e;

endpackage

// File: rtl/sad_buffer_sequencer_if.sv
// Bundles the byte stream, both buffer write/clear/full ports, the SAD unit handshake and search status.
interface sad_buffer_sequencer_if;
   import sad_buffer_sequencer_pkg::*;

   // A byte moves on any cycle where in_valid & in_ready; in_valid may be held with in_ready low
   // for any number of cycles and the byte is not taken until in_ready rises.
   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             tpl_wr_en;
   logic [WIDTH-1:0] tpl_data;
   logic             tpl_full;
   logic             tpl_clr;
   logic             cand_wr_en;
   logic [WIDTH-1:0] cand_data;
   logic             cand_full;
   logic             cand_clr;
   logic             sad_start;
   logic             sad_done;
   logic [SAD_W-1:0] sad_value;
   logic [SAD_W-1:0] best_sad;
   logic [IDX_W-1:0] best_idx;
   logic             busy;
   logic             done;
   logic             err;
   state_e           dbg_state;

   modport master (
      input  start, in_valid, in_data, tpl_full, cand_full, sad_done, sad_value,
      output in_ready, tpl_wr_en, tpl_data, tpl_clr, cand_wr_en, cand_data, cand_clr,
             sad_start, best_sad, best_idx, busy, done, err, dbg_state
   );

   modport slave (
      output start, in_valid, in_data, tpl_full, cand_full, sad_done, sad_value,
      input  in_ready, tpl_wr_en, tpl_data, tpl_clr, cand_wr_en, cand_data, cand_clr,
             sad_start, best_sad, best_idx, busy, done, err, dbg_state
   );

endinterface

// File: rtl/sad_best_tracker.sv
// Running minimum of SAD results with the index that produced it; strict compare keeps the earliest tie.
module sad_best_tracker
   import sad_buffer_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             valid_i,
   input  logic [SAD_W-1:0] value_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic [SAD_W-1:0] best_sad_o,
   output logic [IDX_W-1:0] best_idx_o
);

   logic [SAD_W-1:0] best_sad_q, best_sad_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;

   always_comb begin
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
      if (clr_i) begin
         best_sad_d = SAD_MAX;
         best_idx_d = '0;
      end else if (valid_i && (value_i < best_sad_q)) begin
         best_sad_d = value_i;
         best_idx_d = idx_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         best_sad_q <= SAD_MAX;
         best_idx_q <= '0;
      end else begin
         best_sad_q <= best_sad_d;
         best_idx_q <= best_idx_d;
      end
   end

   assign best_sad_o = best_sad_q;
   assign best_idx_o = best_idx_q;

endmodule

// File: rtl/sad_buffer_sequencer.sv
// Sequences template and candidate buffer fills and one SAD run per candidate for a block search.
// Optional macro SAD_EARLY_EXIT_EN: a zero SAD result records the candidate and ends the search.
module sad_buffer_sequencer
   import sad_buffer_sequencer_pkg::*;
(
   input logic                    clk,
   input logic                    rst,
   sad_buffer_sequencer_if.master bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
   logic             err_q, err_d;
   logic             buf_open, last_cand, in_ready;
   logic             tpl_clr, cand_clr, sad_start, done, trk_clr, trk_valid;

   assign buf_open = beat_cnt_q < BUF_CNT;

`ifdef SAD_EARLY_EXIT_EN
   assign last_cand = (cand_idx_q == CAND_LAST) || (bus.sad_value == '0);
`else
   assign last_cand = (cand_idx_q == CAND_LAST);
`endif

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      cand_idx_d = cand_idx_q;
      err_d      = err_q;
      in_ready   = 1'b0;
      tpl_clr    = 1'b0;
      cand_clr   = 1'b0;
      sad_start  = 1'b0;
      done       = 1'b0;
      trk_clr    = 1'b0;
      trk_valid  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               err_d   = 1'b0;
               state_d = ST_CLR_ALL;
            end
         end
         ST_CLR_ALL: begin
            tpl_clr    = 1'b1;
            cand_clr   = 1'b1;
            trk_clr    = 1'b1;
            cand_idx_d = '0;
            beat_cnt_d = '0;
            state_d    = ST_LOAD_TPL;
         end
         // An early full flag is flagged but the fill still runs to BUF_SIZE beats.
         ST_LOAD_TPL: begin
            in_ready = buf_open;
            if (bus.in_valid && buf_open) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (bus.tpl_full && buf_open) err_d = 1'b1;
            if (!buf_open && bus.tpl_full) begin
               beat_cnt_d = '0;
               state_d    = ST_LOAD_CAND;
            end
         end
         ST_LOAD_CAND: begin
            in_ready = buf_open;
            if (bus.in_valid && buf_open) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (bus.cand_full && buf_open) err_d = 1'b1;
            if (!buf_open && bus.cand_full) begin
               beat_cnt_d = '0;
               state_d    = ST_RUN_SAD;
            end
         end
         ST_RUN_SAD: begin
            sad_start = 1'b1;
            state_d   = ST_WAIT_SAD;
         end
         ST_WAIT_SAD: begin
            if (bus.sad_done) begin
               trk_valid = 1'b1;
               if (last_cand) begin
                  state_d = ST_DONE;
               end else begin
                  cand_idx_d = cand_idx_q + IDX_W'(1);
                  state_d    = ST_CLR_CAND;
               end
            end
         end
         ST_CLR_CAND: begin
            cand_clr   = 1'b1;
            beat_cnt_d = '0;
            state_d    = ST_LOAD_CAND;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         cand_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         cand_idx_q <= cand_idx_d;
         err_q      <= err_d;
      end
   end

   sad_best_tracker u_best (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (trk_clr),
      .valid_i    (trk_valid),
      .value_i    (bus.sad_value),
      .idx_i      (cand_idx_q),
      .best_sad_o (bus.best_sad),
      .best_idx_o (bus.best_idx)
   );

   assign bus.in_ready   = in_ready;
   assign bus.tpl_wr_en  = (state_q == ST_LOAD_TPL) && in_ready && bus.in_valid;
   assign bus.cand_wr_en = (state_q == ST_LOAD_CAND) && in_ready && bus.in_valid;
   assign bus.tpl_data   = bus.in_data;
   assign bus.cand_data  = bus.in_data;
   assign bus.tpl_clr    = tpl_clr;
   assign bus.cand_clr   = cand_clr;
   assign bus.sad_start  = sad_start;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = done;
   assign bus.err        = err_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_sad_buffer_sequencer.sv
// Self-checking bench: buffer/SAD-unit models, random byte stream, routed-byte and search-result scoreboards.
module tb_sad_buffer_sequencer;
   import sad_buffer_sequencer_pkg::*;

   typedef struct {
      logic [SAD_W-1:0] sad;
      logic [IDX_W-1:0] idx;
      logic             err;
      int               n_start;
      int               n_cclr;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sad_buffer_sequencer_if bus ();
   sad_buffer_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   int               n_checks = 0;
   int               n_fail   = 0;
   int               n_done   = 0;
   bit               abort    = 1'b0;
   logic [SAD_W-1:0] sad_vals[NUM_CAND];
   logic [WIDTH:0]   exp_q[$];
   res_t             res_q[$];

   int tpl_cnt, cand_cnt, sad_seen;
   int sad_lat_lo = 1;
   int sad_lat_hi = 4;
   bit force_tpl_full = 1'b0;
   bit stray_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Buffer fill counters and a SAD unit with random latency, updated just after each edge.
   initial begin : env
      int pend, pidx;
      bit c_twe, c_cwe, c_tclr, c_cclr, c_st, c_rst;
      pend = 0; pidx = 0; tpl_cnt = 0; cand_cnt = 0; sad_seen = 0;
      bus.tpl_full = 1'b0; bus.cand_full = 1'b0; bus.sad_done = 1'b0; bus.sad_value = '0;
      forever begin
         @(negedge clk);
         c_twe = bus.tpl_wr_en; c_cwe = bus.cand_wr_en; c_tclr = bus.tpl_clr;
         c_cclr = bus.cand_clr; c_st = bus.sad_start; c_rst = rst;
         @(posedge clk); #1;
         bus.sad_done = 1'b0;
         if (c_rst) begin
            tpl_cnt = 0; cand_cnt = 0; pend = 0; sad_seen = 0;
         end else begin
            if (c_tclr) begin tpl_cnt = 0; sad_seen = 0; end
            else if (c_twe) tpl_cnt++;
            if (c_cclr) cand_cnt = 0;
            else if (c_cwe) cand_cnt++;
            if (c_st) begin
               pend = int'($urandom_range(sad_lat_hi, sad_lat_lo));
               pidx = sad_seen;
               sad_seen++;
            end else if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  bus.sad_done  = 1'b1;
                  bus.sad_value = sad_vals[pidx % NUM_CAND];
               end
            end else if (stray_req) begin
               bus.sad_done  = 1'b1;
               bus.sad_value = '0;
               stray_req     = 1'b0;
            end
         end
         bus.tpl_full  = force_tpl_full || (tpl_cnt >= BUF_SIZE);
         bus.cand_full = (cand_cnt >= BUF_SIZE);
      end
   end

   // Monitor: every write is popped against the byte scoreboard, every done against the result queue.
   initial begin : monitor
      int m_start, m_cclr, m_twr, m_cwr;
      logic [WIDTH:0] e;
      res_t r;
      m_start = 0; m_cclr = 0; m_twr = 0; m_cwr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_start = 0; m_cclr = 0; m_twr = 0; m_cwr = 0;
         end else begin
            if (bus.tpl_wr_en && bus.cand_wr_en) chk("both_wr_en", 1, 0);
            if (bus.tpl_wr_en || bus.cand_wr_en) begin
               if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("write_route_cand", 32'(bus.cand_wr_en), 32'(e[WIDTH]));
                  chk("write_data", bus.cand_wr_en ? 32'(bus.cand_data) : 32'(bus.tpl_data),
                      32'(e[WIDTH-1:0]));
               end
               if (bus.tpl_wr_en) m_twr++;
               if (bus.cand_wr_en) m_cwr++;
            end
            if (bus.tpl_clr) begin m_start = 0; m_cclr = 0; m_twr = 0; end
            if (bus.cand_clr) begin m_cclr++; m_cwr = 0; end
            if (bus.sad_start) m_start++;
            if (bus.done) begin
               n_done++;
               if (res_q.size() == 0) chk("unexpected_done", 1, 0);
               else begin
                  r = res_q.pop_front();
                  chk("best_sad", 32'(bus.best_sad), 32'(r.sad));
                  chk("best_idx", 32'(bus.best_idx), 32'(r.idx));
                  chk("err_at_done", 32'(bus.err), 32'(r.err));
                  chk("sad_start_count", m_start, r.n_start);
                  chk("cand_clr_count", m_cclr, r.n_cclr);
                  chk("tpl_writes", m_twr, BUF_SIZE);
                  chk("last_cand_writes", m_cwr, BUF_SIZE);
               end
            end
         end
      end
   end

   function automatic res_t model_search(input int force_at);
      res_t r;
      r.sad = SAD_MAX; r.idx = '0; r.n_start = 0;
      for (int i = 0; i < NUM_CAND; i++) begin
         r.n_start++;
         if (sad_vals[i] < r.sad) begin
            r.sad = sad_vals[i];
            r.idx = IDX_W'(i);
         end
`ifdef SAD_EARLY_EXIT_EN
         if (sad_vals[i] == '0) break;
`endif
      end
      r.n_cclr = r.n_start;
      r.err = (force_at >= 0) && (force_at < BUF_SIZE);
      return r;
   endfunction

   task automatic send_byte(input logic [WIDTH-1:0] d, input bit is_cand, input int gap);
      bit took;
      int budget;
      if (abort) return;
      repeat (gap) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      exp_q.push_back({is_cand, d});
      took = 1'b0; budget = 0;
      while (!took && budget < 300) begin
         @(negedge clk);
         took = bus.in_ready;
         @(posedge clk); #1;
         budget++;
      end
      bus.in_valid = 1'b0;
      if (!took) begin
         chk("byte_accept_timeout", 0, 1);
         abort = 1'b1;
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
   task automatic run_search(input int gap_mode, input int force_at, input bit stray, input bit dbl_start);
      res_t r;
      int   target, budget, gap;
      if (abort) return;
      r = model_search(force_at);
      res_q.push_back(r);
      target = n_done + 1;
      pulse_start();
      if (stray) stray_req = 1'b1;
      @(negedge clk);
      chk("busy_after_start", 32'(bus.busy), 1);
      @(posedge clk); #1;
      for (int b = 0; b < BUF_SIZE * (r.n_start + 1); b++) begin
         if (b == force_at) force_tpl_full = 1'b1;
         if (dbl_start && b == 200) pulse_start();
         gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(2, 0));
         send_byte(WIDTH'($urandom), b >= BUF_SIZE, gap);
      end
      budget = 0;
      while (!abort && n_done < target && budget < 400) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!abort && n_done < target) begin
         chk("done_timeout", 0, 1);
         abort = 1'b1;
      end
      chk("byte_queue_drained", exp_q.size(), 0);
      force_tpl_full = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_err"}, 32'(bus.err), 0);
      chk({tag, "_best_sad"}, 32'(bus.best_sad), 32'(SAD_MAX));
      chk({tag, "_best_idx"}, 32'(bus.best_idx), 0);
      chk({tag, "_strobes"}, {27'd0, bus.tpl_wr_en, bus.cand_wr_en, bus.tpl_clr, bus.cand_clr,
                               bus.sad_start}, 0);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int budget;
      rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_idle("reset");

      // Ascending SADs; stray sad_done while loading and a start while busy must both be ignored.
      for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'(i + 100);
      run_search(0, -1, 1'b1, 1'b1);

      // Tie on the minimum keeps the earlier index.
      sad_vals[0] = 15'd500; sad_vals[1] = 15'd300; sad_vals[2] = 15'd300; sad_vals[3] = 15'd700;
      for (int i = 4; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(2000, 301));
      run_search(2, -1, 1'b0, 1'b0);

      // Alternate-cycle valid, random results.
      for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(5000, 1));
      run_search(1, -1, 1'b0, 1'b0);

      // Template full flag forced early, then a clean search clears err.
      for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(32000, 1));
      run_search(0, 40, 1'b0, 1'b0);
      for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(32000, 1));
      run_search(2, -1, 1'b0, 1'b0);

      // Reset while waiting on the SAD result of candidate 5.
      if (!abort) begin
         sad_lat_lo = 6; sad_lat_hi = 6;
         for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(900, 1));
         pulse_start();
         for (int b = 0; b < BUF_SIZE * 7; b++) send_byte(WIDTH'($urandom), b >= BUF_SIZE, 0);
         budget = 0;
         while (sad_seen < 6 && budget < 400) begin @(posedge clk); #1; budget++; end
         chk("reached_cand5_sad", 32'(sad_seen >= 6), 1);
         @(posedge clk); #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         exp_q.delete();
         check_idle("midreset");
         sad_lat_lo = 1; sad_lat_hi = 4;
         for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(3000, 1));
         run_search(2, -1, 1'b0, 1'b0);
      end

`ifdef SAD_EARLY_EXIT_EN
      for (int i = 0; i < NUM_CAND; i++) sad_vals[i] = SAD_W'($urandom_range(1000, 1));
      sad_vals[3] = '0;
      run_search(0, -1, 1'b0, 1'b0);
`endif

      repeat (5) @(posedge clk);
      chk("results_drained", res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
